// File: rtl/mult_arb_pkg.sv
// Shared types and helpers for the multiplier-sharing scheduler and its arbiter.
package mult_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    localparam int MAX_REQ = 32;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Grants are one-hot, so OR-ing the indices of set bits yields the index.
    function automatic int onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/mult_share_arb_rr_pick.sv
// Combinational single-grant picker. MULT_ARB_RR_EN selects round robin starting
// at ptr; without it the lowest requesting index wins and there is no ptr port.
module rr_pick
    import mult_arb_pkg::*;
#(
    parameter int N = 4
`ifdef MULT_ARB_RR_EN
    , parameter int PTR_W = id_width(N)
`endif
) (
    input  logic [N-1:0]     req,
`ifdef MULT_ARB_RR_EN
    input  logic [PTR_W-1:0] ptr,
`endif
    output logic [N-1:0]     gnt
);

`ifdef MULT_ARB_RR_EN
    logic [2*N-1:0] dbl_req;
    logic [2*N-1:0] dbl_gnt;
    logic [N-1:0]   rot_req;
    logic [N-1:0]   rot_gnt;

    // Rotate so ptr sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        dbl_req = {req, req} >> ptr;
        rot_req = dbl_req[N-1:0];
        rot_gnt = rot_req & (~rot_req + N'(1));
        dbl_gnt = {rot_gnt, rot_gnt} << ptr;
        gnt     = dbl_gnt[2*N-1:N];
    end
`else
    assign gnt = req & (~req + N'(1));
`endif

endmodule

// File: rtl/mult_share_arb.sv
// Shares one pipelined multiplier among NUM_REQ requesters, steering each product
// back by a tag pipeline. MULT_ARB_RR_EN enables round robin, else fixed priority.
module mult_share_arb
    import mult_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int LAT     = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_opa,
    input  logic [NUM_REQ*DATA_W-1:0]   req_opb,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [2*DATA_W-1:0]         rsp_data,
    output logic [DATA_W-1:0]           mult_opa,
    output logic [DATA_W-1:0]           mult_opb,
    input  logic [2*DATA_W-1:0]         mult_out,
    output logic                        idle
);

    localparam int ID_W  = id_width(NUM_REQ);
    localparam int CNT_W = $clog2(LAT + 2);

    arb_state_t          state;
    logic [NUM_REQ-1:0]  cand;
    logic [NUM_REQ-1:0]  grant;
    logic                hs;
    logic [ID_W-1:0]     g;
    logic [LAT:0]        vld_p;
    logic [ID_W-1:0]     id_p [LAT+1];
    logic [CNT_W-1:0]    inflight;
    logic [CNT_W-1:0]    inflight_next;

    assign cand      = (state == RUN) ? req_valid : '0;
    assign req_ready = grant;
    assign hs        = |grant;
    assign g         = ID_W'(onehot_to_idx(MAX_REQ'(grant)));

`ifdef MULT_ARB_RR_EN
    logic [ID_W-1:0] ptr;

    rr_pick #(.N(NUM_REQ), .PTR_W(ID_W)) u_pick (
        .req (cand),
        .ptr (ptr),
        .gnt (grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (hs)
            ptr <= (g == ID_W'(NUM_REQ - 1)) ? '0 : g + ID_W'(1);
    end
`else
    rr_pick #(.N(NUM_REQ)) u_pick (
        .req (cand),
        .gnt (grant)
    );
`endif

    // Issue stage: operands captured on handshake, multiplier sees them next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mult_opa <= '0;
            mult_opb <= '0;
        end else if (hs) begin
            mult_opa <= req_opa[g*DATA_W +: DATA_W];
            mult_opb <= req_opb[g*DATA_W +: DATA_W];
        end
    end

    // Tag stages p0..pLAT: stage LAT lines up with mult_out for the tagged operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_p <= '0;
        else
            vld_p <= {vld_p[LAT-1:0], hs};
    end

    always_ff @(posedge clk) begin
        id_p[0] <= g;
        for (int s = 1; s <= LAT; s++) id_p[s] <= id_p[s-1];
    end

    always_comb begin
        rsp_valid = '0;
        if (vld_p[LAT]) rsp_valid[id_p[LAT]] = 1'b1;
    end

    assign rsp_data = mult_out;

    always_comb begin
        inflight_next = inflight;
        if (hs && !vld_p[LAT])
            inflight_next = inflight + CNT_W'(1);
        else if (!hs && vld_p[LAT])
            inflight_next = inflight - CNT_W'(1);
    end

    // Exits test the post-update count so idle rises right after the last response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idle     <= 1'b1;
            inflight <= '0;
        end else begin
            inflight <= inflight_next;
            case (state)
                IDLE: begin
                    if (en) begin
                        state <= RUN;
                        idle  <= 1'b0;
                    end
                end
                RUN: begin
                    if (!en) begin
                        if (inflight_next == '0) begin
                            state <= IDLE;
                            idle  <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (inflight_next == '0) begin
                        state <= IDLE;
                        idle  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    idle  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_arb.sv
// Randomized and directed bench for mult_share_arb against a queue-based model;
// follows MULT_ARB_RR_EN to choose round-robin or fixed-priority expectations.
module tb_mult_share_arb;

    localparam int NR  = 4;
    localparam int DW  = 16;
    localparam int LAT = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 en;
    logic [NR-1:0]        req_valid;
    logic [NR*DW-1:0]     req_opa;
    logic [NR*DW-1:0]     req_opb;
    logic [NR-1:0]        req_ready;
    logic [NR-1:0]        rsp_valid;
    logic [2*DW-1:0]      rsp_data;
    logic [DW-1:0]        mult_opa;
    logic [DW-1:0]        mult_opb;
    logic [2*DW-1:0]      mult_out;
    logic                 idle;

    always #5 clk = ~clk;

    mult_share_arb #(.NUM_REQ(NR), .DATA_W(DW), .LAT(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req_valid (req_valid),
        .req_opa   (req_opa),
        .req_opb   (req_opb),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .mult_opa  (mult_opa),
        .mult_opb  (mult_opb),
        .mult_out  (mult_out),
        .idle      (idle)
    );

    // Stand-in multiplier: LAT register stages from operand capture to out
    logic [2*DW-1:0] mpipe [LAT];
    always_ff @(posedge clk) begin
        mpipe[0] <= (2*DW)'(mult_opa) * (2*DW)'(mult_opb);
        for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
    end
    assign mult_out = mpipe[LAT-1];

    typedef struct {
        int              id;
        logic [2*DW-1:0] prod;
        int              due;
    } rsp_t;

    rsp_t         exp_q[$];
    int           m_state;
    int           m_ptr;
    logic [DW-1:0] m_opa, m_opb;
    int           cyc;
    int           n_tests;
    int           n_fail;
    int           peak;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int pick(input logic [NR-1:0] v, input int start);
        for (int k = 0; k < NR; k++) begin
            if (v[(start + k) % NR]) return (start + k) % NR;
        end
        return -1;
    endfunction

    function automatic logic [NR*DW-1:0] ops_idx();
        logic [NR*DW-1:0] r;
        for (int i = 0; i < NR; i++) r[i*DW +: DW] = DW'(i + 1);
        return r;
    endfunction

    function automatic logic [NR*DW-1:0] rep(input logic [DW-1:0] x);
        return {NR{x}};
    endfunction

    function automatic logic [NR*DW-1:0] rnd_ops();
        logic [NR*DW-1:0] r;
        for (int i = 0; i < NR; i++) r[i*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    // One clock cycle: drive, compare against the model, then advance the model.
    task automatic step(input logic e, input logic [NR-1:0] v, input logic r,
                        input logic [NR*DW-1:0] a, input logic [NR*DW-1:0] b);
        int              g;
        int              start;
        bit              due_now;
        logic [NR-1:0]   exp_rdy;
        logic [NR-1:0]   exp_rv;
        rsp_t            ent;
        @(posedge clk);
        #1;
        en = e; req_valid = v; req_opa = a; req_opb = b; rst_n = r;
        if (!r) begin
            exp_q.delete();
            m_state = 0; m_ptr = 0; m_opa = '0; m_opb = '0;
        end
        #1;
`ifdef MULT_ARB_RR_EN
        start = m_ptr;
`else
        start = 0;
`endif
        g = (r && m_state == 1) ? pick(v, start) : -1;
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        due_now = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        exp_rv = '0;
        if (due_now) exp_rv[exp_q[0].id] = 1'b1;

        check_eq("req_ready", 64'(req_ready), 64'(exp_rdy));
        check_eq("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        if (due_now) check_eq("rsp_data", 64'(rsp_data), 64'(exp_q[0].prod));
        check_eq("idle", 64'(idle), 64'(m_state == 0));
        check_eq("mult_opa", 64'(mult_opa), 64'(m_opa));
        check_eq("mult_opb", 64'(mult_opb), 64'(m_opb));
        check_eq("inflight", 64'(dut.inflight), 64'(exp_q.size()));
        if (int'(dut.inflight) > peak) peak = int'(dut.inflight);

        if (r) begin
            if (due_now) void'(exp_q.pop_front());
            if (g >= 0) begin
                m_opa = a[g*DW +: DW];
                m_opb = b[g*DW +: DW];
                ent.id   = g;
                ent.prod = (2*DW)'(m_opa) * (2*DW)'(m_opb);
                ent.due  = cyc + LAT + 1;
                exp_q.push_back(ent);
                m_ptr = (g + 1) % NR;
            end
            case (m_state)
                0: if (e) m_state = 1;
                1: if (!e) m_state = (exp_q.size() == 0) ? 0 : 2;
                default: if (exp_q.size() == 0) m_state = 0;
            endcase
        end
        cyc++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1);
    end

    initial begin
        logic           e, r;
        logic [NR-1:0]  v;
        rst_n = 1'b0; en = 1'b0; req_valid = '0; req_opa = '0; req_opb = '0;
        n_tests = 0; n_fail = 0; cyc = 0; peak = 0;
        m_state = 0; m_ptr = 0; m_opa = '0; m_opb = '0;

        repeat (3) step(1'b0, '0, 1'b0, '0, '0);

        // Enable, then every requester offering i+1 times 3
        step(1'b1, '0, 1'b1, '0, '0);
        repeat (8) step(1'b1, '1, 1'b1, ops_idx(), rep(DW'(3)));
        repeat (8) step(1'b1, '0, 1'b1, '0, '0);

        // Single requester with maximal operands
        repeat (8) step(1'b1, 4'b0100, 1'b1, rep('1), rep('1));
        repeat (6) step(1'b1, '0, 1'b1, '0, '0);

        // Drain with requests still pending, then re-enable
        repeat (3)  step(1'b1, '1, 1'b1, rnd_ops(), rnd_ops());
        repeat (10) step(1'b0, '1, 1'b1, rnd_ops(), rnd_ops());
        repeat (6)  step(1'b1, '1, 1'b1, rnd_ops(), rnd_ops());
        repeat (8)  step(1'b1, '0, 1'b1, '0, '0);

        // Two requesters contending continuously
        repeat (8) step(1'b1, 4'b1010, 1'b1, rnd_ops(), rnd_ops());
        repeat (6) step(1'b1, '0, 1'b1, '0, '0);

        // Reset while two products are in flight
        repeat (2) step(1'b1, '1, 1'b1, rnd_ops(), rnd_ops());
        repeat (2) step(1'b1, '0, 1'b1, '0, '0);
        step(1'b1, '0, 1'b0, '0, '0);
        repeat (8) step(1'b0, '0, 1'b1, '0, '0);

        // Six back-to-back handshakes to reach the in-flight ceiling
        step(1'b1, '0, 1'b1, '0, '0);
        peak = 0;
        repeat (6) step(1'b1, 4'b0001, 1'b1, rnd_ops(), rnd_ops());
        repeat (8) step(1'b1, '0, 1'b1, '0, '0);
        check_eq("inflight_peak", 64'(peak), 64'(LAT + 1));

        repeat (400) begin
            e = ($urandom_range(0, 9) != 0);
            r = ($urandom_range(0, 99) != 0);
            v = NR'($urandom);
            step(e, v, r, rnd_ops(), rnd_ops());
        end
        repeat (10) step(1'b1, '0, 1'b1, '0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
